// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the pipelined add/sub datapath
package adder_pkg;
    localparam int MAX_W = 64;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction
    typedef struct packed {
        logic valid;
        logic [MAX_W-1:0] a_rem;
        logic [MAX_W-1:0] b_rem;
        logic [MAX_W-1:0] sum_acc;
        logic carry;
        logic msb_cin;
    } stage_t;
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CW-bit ripple adder with MSB carry-in tap
module chunk_adder #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          carry_out,
    output logic          msb_carry_in
);
    logic [CW:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < CW; i++) begin : g_fa
        full_adder u_fa (.a(a[i]), .b(b[i]), .cin(c[i]), .sum(sum[i]), .cout(c[i+1]));
    end
    assign carry_out = c[CW];
    assign msb_carry_in = c[CW-1];
endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: chunked, pipelined add/sub with valid/ready handshake
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    input  logic             c_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             overflow_out
);
    localparam int CW = chunk_width(WIDTH, STAGES);
    localparam int L = STAGES - 1;
    stage_t st [STAGES];
    stage_t src [STAGES];
    logic [CW-1:0] ch_sum [STAGES];
    logic ch_co [STAGES];
    logic ch_mc [STAGES];
    logic [WIDTH-1:0] bx;
    logic adv;
    assign bx = (sub_in == OP_ADD) ? b_in : ~b_in;
    assign adv = ~st[L].valid | ready_in;
    assign ready_out = adv;
    assign valid_out = st[L].valid;
    assign sum_out = st[L].sum_acc[WIDTH-1:0];
    assign carry_out = st[L].carry;
    assign overflow_out = st[L].carry ^ st[L].msb_cin;
    // stage inputs: prepped operands for stage 0, previous stage registers otherwise
    always_comb begin
        src[0] = '{valid: valid_in, a_rem: MAX_W'(a_in), b_rem: MAX_W'(bx), sum_acc: '0,
                   carry: (sub_in == OP_SUB) ? 1'b1 : c_in, msb_cin: 1'b0};
        for (int i = 1; i < STAGES; i++) src[i] = st[i-1];
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(.CW(CW)) u_chunk (
            .a(src[k].a_rem[CW-1:0]),
            .b(src[k].b_rem[CW-1:0]),
            .cin(src[k].carry),
            .sum(ch_sum[k]),
            .carry_out(ch_co[k]),
            .msb_carry_in(ch_mc[k])
        );
    end
    // advance every stage together; consumed operand chunks shift out, sum chunks accumulate
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < STAGES; i++) st[i] <= '0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++)
                st[i] <= '{valid: src[i].valid,
                           a_rem: src[i].a_rem >> CW,
                           b_rem: src[i].b_rem >> CW,
                           sum_acc: src[i].sum_acc | (MAX_W'(ch_sum[i]) << (i * CW)),
                           carry: ch_co[i],
                           msb_cin: (i == L) ? ch_mc[i] : 1'b0};
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench sweeping STAGES in {1,2,4,16} at WIDTH=16
module tb_pipelined_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic co;
        logic ov;
        int acc;
        int s0;
        bit seen;
    } exp_t;

    logic clk = 0;
    logic rst_in, valid_in, ready_in, sub, cin;
    logic [15:0] a, b;
    logic vo [4];
    logic ro [4];
    logic [15:0] so [4];
    logic co [4];
    logic ov [4];
    int pending [4];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    function automatic exp_t model(input logic [15:0] xa, input logic [15:0] xb, input logic xs, input logic xc);
        exp_t e;
        int unsigned full;
        e = '0;
        if (xs) begin
            e.sum = xa - xb;
            e.co = xa >= xb;
            e.ov = (xa[15] != xb[15]) && (e.sum[15] != xa[15]);
        end else begin
            full = xa + xb + xc;
            e.sum = full[15:0];
            e.co = full[16];
            e.ov = (xa[15] == xb[15]) && (e.sum[15] != xa[15]);
        end
        return e;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'hFFFF;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 16;
        exp_t q [$];
        exp_t e;
        int stalls = 0;
        pipelined_adder #(.WIDTH(16), .STAGES(S)) dut (
            .clk_in(clk), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ro[g]),
            .a_in(a), .b_in(b), .sub_in(sub), .c_in(cin),
            .valid_out(vo[g]), .ready_in(ready_in), .sum_out(so[g]),
            .carry_out(co[g]), .overflow_out(ov[g])
        );
        always @(negedge clk) begin
            if (vo[g] === 1'b1) begin
                chk(q.size() > 0, $sformatf("s%0d spurious_valid", S), 1, q.size());
                if (q.size() > 0) begin
                    chk(so[g] == q[0].sum, $sformatf("s%0d sum", S), so[g], q[0].sum);
                    chk(co[g] == q[0].co, $sformatf("s%0d carry", S), co[g], q[0].co);
                    chk(ov[g] == q[0].ov, $sformatf("s%0d overflow", S), ov[g], q[0].ov);
                    if (!q[0].seen) begin
                        chk(cyc - q[0].acc == S - 1 + stalls - q[0].s0, $sformatf("s%0d latency", S),
                            cyc - q[0].acc, S - 1 + stalls - q[0].s0);
                        q[0].seen = 1'b1;
                    end
                    if (ready_in) void'(q.pop_front());
                end
            end
            if (rst_in) begin
                q.delete();
            end else begin
                if (vo[g] === 1'b1 && !ready_in) stalls++;
                if (valid_in && ro[g] === 1'b1) begin
                    e = model(a, b, sub, cin);
                    e.acc = cyc + 1;
                    e.s0 = stalls;
                    q.push_back(e);
                end
            end
            pending[g] = q.size();
        end
    end

    task automatic op_lit(input logic [15:0] xa, input logic [15:0] xb, input logic xs, input logic xc,
                          input logic [15:0] ws, input logic wc, input logic wo);
        a = xa; b = xb; sub = xs; cin = xc; valid_in = 1;
        @(posedge clk); #1 valid_in = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(vo[2] == 1'b1, "lit valid", vo[2], 1);
        chk(so[2] == ws, "lit sum", so[2], ws);
        chk(co[2] == wc, "lit carry", co[2], wc);
        chk(ov[2] == wo, "lit overflow", ov[2], wo);
        @(posedge clk); #1;
    endtask

    task automatic pin(input logic [15:0] xa, input logic [15:0] xb, input logic xs, input logic xc,
                       input logic [15:0] ws, input logic wc, input logic wo);
        exp_t e;
        e = model(xa, xb, xs, xc);
        chk(e.sum == ws, "model sum", e.sum, ws);
        chk(e.co == wc, "model carry", e.co, wc);
        chk(e.ov == wo, "model overflow", e.ov, wo);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] hs;
        logic hc, ho;
        int seen;
        rst_in = 1; valid_in = 0; ready_in = 0; a = 0; b = 0; sub = 0; cin = 0;
        repeat (2) @(posedge clk);
        #1 rst_in = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk(vo[i] == 1'b0, "reset valid_out", vo[i], 0);
            chk(so[i] == 16'h0, "reset sum_out", so[i], 0);
            chk(co[i] == 1'b0, "reset carry_out", co[i], 0);
            chk(ov[i] == 1'b0, "reset overflow_out", ov[i], 0);
            chk(ro[i] == 1'b1, "reset ready_out", ro[i], 1);
        end
        @(posedge clk); #1 ready_in = 1;

        pin(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
        pin(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        pin(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        pin(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0);
        pin(16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1);

        op_lit(16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
        op_lit(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        op_lit(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        op_lit(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0);
        op_lit(16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1, 1);
        op_lit(16'h1234, 16'h0FFF, 0, 1, 16'h2234, 0, 0);

        for (int i = 0; i < 8; i++) begin
            a = pick(); b = pick(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            valid_in = 1;
            @(posedge clk); #1;
        end
        valid_in = 0; ready_in = 0;
        @(negedge clk);
        hs = so[2]; hc = co[2]; ho = ov[2];
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk(ro[2] == 1'b0, "stall ready_out", ro[2], 0);
            chk(vo[2] == 1'b1, "stall valid_out", vo[2], 1);
            chk({so[2], co[2], ov[2]} == {hs, hc, ho}, "stall hold", {so[2], co[2], ov[2]}, {hs, hc, ho});
        end
        @(posedge clk); #1;
        a = 16'h4000; b = 16'h4000; sub = 0; cin = 0; valid_in = 1; ready_in = 1;
        @(negedge clk);
        chk(ro[2] == 1'b1, "ready_in to ready_out", ro[2], 1);
        @(posedge clk); #1 valid_in = 0;
        repeat (20) @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            a = pick(); b = pick(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            valid_in = 1;
            @(posedge clk); #1;
        end
        valid_in = 0; rst_in = 1;
        @(posedge clk); #1 rst_in = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk(vo[i] == 1'b0, "flush valid_out", vo[i], 0);
            chk(so[i] == 16'h0, "flush sum_out", so[i], 0);
            chk(co[i] == 1'b0, "flush carry_out", co[i], 0);
            chk(ov[i] == 1'b0, "flush overflow_out", ov[i], 0);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (vo[2] !== 1'b0) seen++;
        end
        chk(seen == 0, "flushed ops emerged", seen, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 1000; i++) begin
            a = pick(); b = pick(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            valid_in = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 300; i++) begin
            a = pick(); b = pick(); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            valid_in = $urandom_range(0, 3) != 0;
            ready_in = $urandom_range(0, 2) != 0;
            @(posedge clk); #1;
        end
        valid_in = 0; ready_in = 1;
        for (int i = 0; i < 80; i++) begin
            if (pending[0] + pending[1] + pending[2] + pending[3] == 0) break;
            @(posedge clk);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) chk(pending[i] == 0, "drain pending", pending[i], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
